// File: rtl/seg_pkg.sv
// seg_pkg: shared states, segment patterns and digit count for the display scan path
package seg_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  localparam int NUM_DIGITS = 3;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF = 7'h00;
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: BCD/control inputs and scanned display outputs of the scan scheduler
interface seg_scan_ctrl_if;
  import seg_pkg::*;
  logic en;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic lz_blank;
  logic [6:0] seg_out;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic frame_start;
  modport master (output en, bcd_in, lz_blank, input seg_out, digit_sel, frame_start);
  modport slave (input en, bcd_in, lz_blank, output seg_out, digit_sel, frame_start);
endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD nibble to {g,f,e,d,c,b,a} segments; non-decimal nibbles show a dash
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: snapshots a 3-digit BCD value per frame and time-multiplexes it onto one
// segment bus with a per-digit dwell, a blanking guard and optional leading-zero blanking
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input logic clk,
  input logic rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int MAX_CYC = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam state_t GAP = BLANK_CYCLES == 0 ? SHOW : BLANK;
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [11:0] snap, snap_n;
  logic lz, lz_n;
  logic [3:0] nib;
  logic blank;
  logic [6:0] dec, seg_q, seg_n;
  logic [2:0] sel_q, sel_n;
  logic fs_q, fs_n;
  bcd_to_seg7 u_dec (.bcd(nib), .seg(dec));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      snap <= '0;
      lz <= 1'b0;
      seg_q <= SEG_OFF;
      sel_q <= '0;
      fs_q <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      snap <= snap_n;
      lz <= lz_n;
      seg_q <= seg_n;
      sel_q <= sel_n;
      fs_q <= fs_n;
    end
  end
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    snap_n = snap;
    lz_n = lz;
    fs_n = 1'b0;
    if (!bus.en) begin
      state_n = IDLE;
      idx_n = '0;
      cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = GAP;
          idx_n = '0;
          cnt_n = '0;
          snap_n = bus.bcd_in;
          lz_n = bus.lz_blank;
          fs_n = 1'b1;
        end
        BLANK: begin
          state_n = cnt == BLANK_LAST ? SHOW : BLANK;
          cnt_n = cnt == BLANK_LAST ? '0 : cnt + 1'b1;
        end
        SHOW: begin
          cnt_n = cnt == DWELL_LAST ? '0 : cnt + 1'b1;
          if (cnt == DWELL_LAST) begin
            state_n = GAP;
            idx_n = idx == 2'd2 ? 2'd0 : idx + 2'd1;
            if (idx == 2'd2) begin
              snap_n = bus.bcd_in;
              lz_n = bus.lz_blank;
              fs_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  // Outputs are registered from the next-state values so they change on the transition edge
  always_comb begin
    nib = idx_n == 2'd2 ? snap_n[11:8] : idx_n == 2'd1 ? snap_n[7:4] : snap_n[3:0];
    blank = lz_n && ((idx_n == 2'd2 && snap_n[11:8] == 4'd0) || (idx_n == 2'd1 && snap_n[11:4] == 8'd0));
    sel_n = state_n == SHOW ? 3'b001 << idx_n : 3'b000;
    seg_n = state_n == SHOW && !blank ? dec : SEG_OFF;
  end
  assign bus.seg_out = seg_q;
  assign bus.digit_sel = sel_q;
  assign bus.frame_start = fs_q;
endmodule
